psi_fold_ctrl: RTL and testbench

- Sequential, folded controller for PSI set intersection: one W-bit AND stage reused over up to N set bitmaps streamed in one per handshake.
- Replaces the fully unrolled N-way AND chain when area matters more than latency.
- Sits between the set-bitmap source (input valid/ready stream) and the result consumer (output valid/ready).
- Also returns the intersection cardinality (popcount of the result).

---
 rtl/psi_pkg.sv | 36 +++
 rtl/psi_popcount.sv | 23 ++
 rtl/psi_fold_ctrl.sv | 147 ++++++++++++++
 tb/tb_psi_fold_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psi_pkg.sv
// psi_pkg: shared types and helpers for the folded PSI intersection controller.
//   - psi_fold_state_t : controller state encoding (IDLE, ACCUM, DONE)
//   - psi_cw / psi_pw  : derived widths for the set counter and the cardinality
//   - popcount         : number of set bits in a vector of up to POP_MAX_W bits
package psi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } psi_fold_state_t;

    // Widest bitmap the popcount helper can handle; narrower vectors are zero-extended.
    localparam int POP_MAX_W = 1024;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int psi_cw(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of a popcount result for a w-bit vector (values 0..w).
    function automatic int psi_pw(input int w);
        return $clog2(w + 1);
    endfunction

    // Count the ones in v.
    function automatic int popcount(input logic [POP_MAX_W-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/psi_popcount.sv
// psi_popcount: purely combinational population count.
//   vec [W-1:0]  : input vector
//   cnt [PW-1:0] : number of ones in vec
module psi_popcount
    import psi_pkg::*;
#(
    parameter  int W  = 32,
    localparam int PW = psi_pw(W)
) (
    input  logic [W-1:0]  vec,
    output logic [PW-1:0] cnt
);

    logic [POP_MAX_W-1:0] vec_ext_s;

    // Zero-extend to the helper width and count.
    always_comb begin
        vec_ext_s          = '0;
        vec_ext_s[W-1:0]   = vec;
        cnt                = PW'(popcount(vec_ext_s));
    end

endmodule

// File: rtl/psi_fold_ctrl.sv
// psi_fold_ctrl: folded PSI set-intersection controller. A single W-bit AND
// stage is reused across up to N set bitmaps that arrive one per handshake.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, num_sets       : job request and its set count (latched in IDLE)
//   abort                 : synchronous job cancel, highest priority
//   busy, err             : job in progress / one-cycle bad-start pulse
//   in_valid/in_ready/in_data    : set bitmap stream
//   out_valid/out_ready/out_data : intersection result
//   out_count             : popcount of out_data
module psi_fold_ctrl
    import psi_pkg::*;
#(
    parameter  int W  = 32,
    parameter  int N  = 1024,
    localparam int CW = psi_cw(N),
    localparam int PW = psi_pw(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] num_sets,
    input  logic          abort,
    output logic          busy,
    output logic          err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [PW-1:0] out_count
);

    psi_fold_state_t state_r;
    logic [W-1:0]    acc_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   target_r;
    logic            busy_r;
    logic            err_r;
    logic            out_valid_r;
    logic [W-1:0]    out_data_r;
    logic            num_ok_s;
    logic [PW-1:0]   acc_pc_s;

    // A job must contain between 1 and N sets.
    assign num_ok_s = (num_sets != CW'(0)) && (num_sets <= CW'(N));

    psi_popcount #(.W(W)) u_popcount (
        .vec (acc_r),
        .cnt (acc_pc_s)
    );

    // Job FSM, set counter, accumulator and registered status/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= '1;
            cnt_r       <= CW'(0);
            target_r    <= CW'(0);
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= W'(0);
        end else begin
            err_r <= 1'b0;
            if (abort) begin
                // Cancel wins over every transition; any pending result is dropped.
                state_r     <= IDLE;
                acc_r       <= '1;
                cnt_r       <= CW'(0);
                target_r    <= CW'(0);
                busy_r      <= 1'b0;
                out_valid_r <= 1'b0;
                out_data_r  <= W'(0);
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            if (num_ok_s) begin
                                state_r  <= ACCUM;
                                target_r <= num_sets;
                                acc_r    <= '1;
                                cnt_r    <= CW'(0);
                                busy_r   <= 1'b1;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end
                    end
                    ACCUM: begin
                        if (in_valid) begin
                            acc_r <= acc_r & in_data;
                            cnt_r <= cnt_r + CW'(1);
                            // Last beat of the job: publish the result next cycle.
                            if (cnt_r == (target_r - CW'(1))) begin
                                state_r     <= DONE;
                                out_valid_r <= 1'b1;
                                out_data_r  <= acc_r & in_data;
                            end
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            state_r     <= IDLE;
                            busy_r      <= 1'b0;
                            out_valid_r <= 1'b0;
                            out_data_r  <= W'(0);
                        end
                    end
                    default: begin
                        state_r     <= IDLE;
                        acc_r       <= '1;
                        cnt_r       <= CW'(0);
                        target_r    <= CW'(0);
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b0;
                        out_data_r  <= W'(0);
                    end
                endcase
            end
        end
    end

    // in_ready depends only on state and abort, never on in_valid.
    always_comb begin
        if ((state_r == ACCUM) && !abort) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // The cardinality is only meaningful while a result is presented.
    always_comb begin
        if (out_valid_r) begin
            out_count = acc_pc_s;
        end else begin
            out_count = PW'(0);
        end
    end

    assign busy      = busy_r;
    assign err       = err_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_psi_fold_ctrl.sv
// tb_psi_fold_ctrl: self-checking bench for psi_fold_ctrl (W=8, N=4).
// A job-level reference model (list of accepted bitmaps, AND-reduced when the
// job is complete) is checked against the DUT on every negative clock edge;
// directed jobs also pin the model with hand-computed literal results.
module tb_psi_fold_ctrl;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 3;
    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_sets;
    logic          abort;
    logic          busy;
    logic          err;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [PW-1:0] out_count;

    int n_cmp  = 0;
    int n_fail = 0;

    psi_fold_ctrl #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_sets  (num_sets),
        .abort     (abort),
        .busy      (busy),
        .err       (err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (job level) ----------------
    // phase: 0 = no job, 1 = collecting bitmaps, 2 = result on offer
    int          m_phase = 0;
    int          m_need  = 0;
    logic [W-1:0] m_beats[$];
    logic [W-1:0] m_res  = '0;
    logic        m_err   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_need  = 0;
            m_beats.delete();
            m_res   = '0;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            if (abort) begin
                m_phase = 0;
                m_beats.delete();
            end else if (m_phase == 0) begin
                if (start) begin
                    if (int'(num_sets) >= 1 && int'(num_sets) <= N) begin
                        m_phase = 1;
                        m_need  = int'(num_sets);
                        m_beats.delete();
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (m_phase == 1) begin
                if (in_valid) begin
                    m_beats.push_back(in_data);
                    if (m_beats.size() == m_need) begin
                        m_res = '1;
                        foreach (m_beats[i]) m_res = m_res & m_beats[i];
                        m_phase = 2;
                    end
                end
            end else begin
                if (out_ready) m_phase = 0;
            end
        end
    end

    // Compare process: every negedge, outputs against the model.
    always @(negedge clk) begin
        logic [W-1:0] e_data;
        e_data = (m_phase == 2) ? m_res : '0;
        chk("busy",      32'(busy),      32'(m_phase != 0));
        chk("err",       32'(err),       32'(m_err));
        chk("in_ready",  32'(in_ready),  32'((m_phase == 1) && !abort));
        chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
        chk("out_data",  32'(out_data),  32'(e_data));
        chk("out_count", 32'(out_count), 32'($countones(e_data)));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; num_sets = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    endtask

    task automatic start_job(input int k);
        start = 1'b1; num_sets = CW'(k);
        tick();
        start = 1'b0; num_sets = '0;
    endtask

    task automatic send_beat(input logic [W-1:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0; in_data = '0;
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_out_data", 32'(out_data),  32'd0);
        chk("rst_count",    32'(out_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd0);
        rst_n = 1'b1;
        tick();

        // Three-set job, back-to-back beats.
        start_job(3);
        send_beat(8'hF3);
        send_beat(8'h7E);
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        chk("j3_valid_latency", 32'(out_valid), 32'd1);
        chk("j3_data",  32'(out_data),  32'h52);
        chk("j3_count", 32'(out_count), 32'd3);
        take_result();
        chk("j3_busy_after", 32'(busy), 32'd0);
        chk("j3_data_after", 32'(out_data), 32'd0);

        // Single-set job.
        start_job(1);
        send_beat(8'hA5);
        wait_result("j1");
        chk("j1_data",  32'(out_data),  32'hA5);
        chk("j1_count", 32'(out_count), 32'd4);
        take_result();

        // Maximum-size job with an all-zero bitmap.
        start_job(4);
        send_beat(8'h00);
        send_beat(8'hFF);
        send_beat(8'hFF);
        send_beat(8'hFF);
        wait_result("j4");
        chk("j4_data",  32'(out_data),  32'h00);
        chk("j4_count", 32'(out_count), 32'd0);
        take_result();

        // Rejected starts.
        start_job(0);
        chk("err0_pulse", 32'(err), 32'd1);
        chk("err0_busy",  32'(busy), 32'd0);
        tick();
        chk("err0_clear", 32'(err), 32'd0);
        start_job(5);
        chk("err5_pulse",    32'(err), 32'd1);
        chk("err5_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("err5_clear", 32'(err), 32'd0);

        // Gapped input and held-off output.
        start_job(2);
        send_beat(8'hCC);
        tick();
        send_beat(8'hAA);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'h00;
            chk("hold_data",     32'(out_data),  32'h88);
            chk("hold_count",    32'(out_count), 32'd2);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
            tick();
        end
        in_valid = 1'b0;
        take_result();

        // Abort with a beat presented in the abort cycle.
        start_job(3);
        send_beat(8'hF0);
        send_beat(8'hF3);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h00;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_idle", 32'(busy), 32'd0);
        start_job(2);
        send_beat(8'hFF);
        send_beat(8'h0F);
        wait_result("post_abort");
        chk("post_abort_data", 32'(out_data), 32'h0F);
        take_result();

        // Asynchronous reset while a result is on offer.
        start_job(1);
        send_beat(8'h3C);
        wait_result("pre_rst");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data",  32'(out_data),  32'd0);
        #2;
        rst_n = 1'b1;
        start_job(2);
        chk("arst_restart_busy", 32'(busy), 32'd1);
        send_beat(8'h81);
        send_beat(8'hFF);
        wait_result("post_rst");
        chk("post_rst_data", 32'(out_data), 32'h81);
        take_result();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 3) == 0);
            num_sets  = CW'($urandom_range(0, 7));
            abort     = ($urandom_range(0, 31) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
